// File: rtl/multiplicador_modo_if.sv
// Start/done handshake bundle for the sequential signed/unsigned multiplier.
// The controller side is the master; the multiplier is the slave.
interface multiplicador_modo_if #(
  parameter int N = 4
);
  logic             start;
  logic             signed_mode;
  logic [N-1:0]     B_in;
  logic [N-1:0]     Q_in;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   P_out;

  modport master (
    output start, signed_mode, B_in, Q_in,
    input  busy, done, P_out
  );

  modport slave (
    input  start, signed_mode, B_in, Q_in,
    output busy, done, P_out
  );
endinterface

// File: rtl/multiplicador_modo.sv
// Sequential shift-add multiplier: N iterations on unsigned magnitudes, then one
// cycle that applies the sign. P_out holds the last product until the next one.
module multiplicador_modo #(
  parameter int N = 4
) (
  input logic                 clk,
  input logic                 rst,
  multiplicador_modo_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [N-1:0]  acc_hi;
  logic          neg;
  logic [CW-1:0] count;
  logic [N:0]    sum;

  // |x| as an N-bit unsigned value; -2^(N-1) maps onto 2^(N-1), which still fits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic is_signed);
    logic signed [N-1:0] xs;
    xs = x;
    return (is_signed && xs < 0) ? (~x + N'(1)) : x;
  endfunction

  // Two's-complement negation of the magnitude product; negating 0 yields 0.
  function automatic logic signed [2*N-1:0] apply_sign(input logic [2*N-1:0] p, input logic n);
    return n ? $signed(~p + (2*N)'(1)) : $signed(p);
  endfunction

  always_comb begin
    sum = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.P_out <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc_hi    <= '0;
      neg       <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mcand    <= magnitude(bus.B_in, bus.signed_mode);
            mplier   <= magnitude(bus.Q_in, bus.signed_mode);
            neg      <= bus.signed_mode & (bus.B_in[N-1] ^ bus.Q_in[N-1]);
            acc_hi   <= '0;
            count    <= CW'(N);
            bus.busy <= 1'b1;
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        // One add-and-shift per cycle; the carry re-enters as the new MSB.
        CALC: begin
          acc_hi <= sum[N:1];
          mplier <= {sum[0], mplier[N-1:1]};
          count  <= count - CW'(1);
          if (count == CW'(1)) state <= SIGN;
        end
        // {acc_hi, mplier} now holds the full magnitude product.
        SIGN: begin
          bus.P_out <= apply_sign({acc_hi, mplier}, neg);
          bus.busy  <= 1'b0;
          bus.done  <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplicador_modo.sv
// Bench for multiplicador_modo at N=4 and N=8 against a cycle-level reference model.
module tb_multiplicador_modo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiplicador_modo_if #(.N(4)) b4 ();
  multiplicador_modo_if #(.N(8)) b8 ();

  multiplicador_modo #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  multiplicador_modo #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  int     checks = 0;
  int     errors = 0;
  bit     chk_en = 1'b0;
  longint edge_cnt = 0;

  // Reference model state, index 0 = N=4 unit, index 1 = N=8 unit.
  bit     m_busy [2];
  bit     m_done [2];
  int     m_p    [2];
  int     m_pend [2];
  longint m_due  [2];

  function automatic int ref_prod(int b, int q, bit m, int n);
    int sb, sq, p;
    sb = b;
    sq = q;
    if (m) begin
      if (b >= (1 << (n - 1))) sb = b - (1 << n);
      if (q >= (1 << (n - 1))) sq = q - (1 << n);
    end
    p = sb * sq;
    return p & ((1 << (2 * n)) - 1);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Operation accepted at edge e delivers its product and done at edge e+n+1.
  task automatic model_step(input int i, input int n, input bit r, input bit s, input bit md,
                            input int b, input int q);
    if (r) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
      m_p[i]    = 0;
      m_due[i]  = -1;
    end else if (m_busy[i] && edge_cnt == m_due[i]) begin
      m_p[i]    = m_pend[i];
      m_done[i] = 1'b1;
      m_busy[i] = 1'b0;
    end else if (!m_busy[i] && s) begin
      m_pend[i] = ref_prod(b, q, md, n);
      m_due[i]  = edge_cnt + n + 1;
      m_busy[i] = 1'b1;
      m_done[i] = 1'b0;
    end else begin
      m_done[i] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    model_step(0, 4, rst, b4.start, b4.signed_mode, int'(b4.B_in), int'(b4.Q_in));
    model_step(1, 8, rst, b8.start, b8.signed_mode, int'(b8.B_in), int'(b8.Q_in));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy4", b4.busy, m_busy[0]);
      check("done4", b4.done, m_done[0]);
      check("p4", b4.P_out, m_p[0]);
      check("excl4", b4.busy & b4.done, 0);
      check("busy8", b8.busy, m_busy[1]);
      check("done8", b8.done, m_done[1]);
      check("p8", b8.P_out, m_p[1]);
      check("excl8", b8.busy & b8.done, 0);
    end
  end

  // Issue one N=4 operation from a falling edge and wait for its done pulse.
  task automatic run4(input logic [3:0] b, input logic [3:0] q, input bit m,
                      output logic [7:0] p, output int lat);
    bit got;
    b4.B_in = b;
    b4.Q_in = q;
    b4.signed_mode = m;
    b4.start = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      b4.start = 1'b0;
      if (b4.done) got = 1'b1;
    end
    check("timeout4", got, 1);
    p = b4.P_out;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] p;
    int lat, pulses;

    rst = 1'b1;
    b4.start = 1'b0; b4.signed_mode = 1'b0; b4.B_in = '0; b4.Q_in = '0;
    b8.start = 1'b0; b8.signed_mode = 1'b0; b8.B_in = '0; b8.Q_in = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_p4", b4.P_out, 0);
    check("reset_busy4", b4.busy, 0);
    rst = 1'b0;

    check("model_uns_max", ref_prod(15, 15, 0, 4), 32'hE1);
    check("model_s_m8m8", ref_prod(8, 8, 1, 4), 32'h40);
    check("model_s_m3p5", ref_prod(13, 5, 1, 4), 32'hF1);
    check("model_s_zero", ref_prod(0, 8, 1, 4), 32'h00);
    check("model_F2_uns", ref_prod(15, 2, 0, 4), 32'h1E);
    check("model_F2_sgn", ref_prod(15, 2, 1, 4), 32'hFE);
    check("model_8b_sgn", ref_prod(8'h80, 8'h7F, 1, 8), 32'hC080);

    // Unsigned max and latency.
    run4(4'hF, 4'hF, 1'b0, p, lat);
    check("uns_max", p, 8'hE1);
    check("latency", lat, 6);
    @(negedge clk);
    check("done_one_cycle", b4.done, 0);

    // Signed corners and mode dependence.
    run4(4'h8, 4'h8, 1'b1, p, lat); check("s_m8m8", p, 8'h40);
    run4(4'hD, 4'h5, 1'b1, p, lat); check("s_m3p5", p, 8'hF1);
    run4(4'h0, 4'h8, 1'b1, p, lat); check("s_zero", p, 8'h00);
    run4(4'hF, 4'h2, 1'b0, p, lat); check("F2_uns", p, 8'h1E);
    run4(4'hF, 4'h2, 1'b1, p, lat); check("F2_sgn", p, 8'hFE);
    @(negedge clk);

    // Start while busy is ignored.
    b4.B_in = 4'd3; b4.Q_in = 4'd5; b4.signed_mode = 1'b0; b4.start = 1'b1;
    @(negedge clk); b4.start = 1'b0;
    @(negedge clk); b4.B_in = 4'd7; b4.Q_in = 4'd7; b4.start = 1'b1;
    @(negedge clk); b4.start = 1'b0;
    pulses = 0;
    p = '0;
    repeat (12) begin
      @(negedge clk);
      if (b4.done) begin pulses++; p = b4.P_out; end
    end
    check("busy_pulses", pulses, 1);
    check("busy_ignore", p, 8'h0F);

    // Reset in the middle of CALC.
    b4.B_in = 4'd9; b4.Q_in = 4'd9; b4.start = 1'b1;
    @(negedge clk); b4.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_busy", b4.busy, 0);
    check("mid_rst_done", b4.done, 0);
    check("mid_rst_p", b4.P_out, 0);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (b4.done) pulses++;
    end
    check("mid_rst_nodone", pulses, 0);
    run4(4'd6, 4'd7, 1'b0, p, lat);
    check("after_rst", p, 8'h2A);
    @(negedge clk);

    // Exhaustive N=4 sweep, back-to-back with start held high.
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < 16; b++)
        for (int q = 0; q < 16; q++) begin
          b4.signed_mode = m[0]; b4.B_in = b[3:0]; b4.Q_in = q[3:0]; b4.start = 1'b1;
          repeat (6) @(negedge clk);
        end
    b4.start = 1'b0;

    // N=8 sweep with random operand pairs.
    for (int k = 0; k < 1000; k++) begin
      b8.signed_mode = 1'($urandom);
      b8.B_in = 8'($urandom);
      b8.Q_in = 8'($urandom);
      b8.start = 1'b1;
      repeat (10) @(negedge clk);
    end
    b8.start = 1'b0;

    // Free-running random traffic: operands and start change every cycle.
    for (int k = 0; k < 300; k++) begin
      b4.start = ($urandom_range(0, 3) == 0);
      b4.signed_mode = 1'($urandom);
      b4.B_in = 4'($urandom);
      b4.Q_in = 4'($urandom);
      b8.start = ($urandom_range(0, 3) == 0);
      b8.signed_mode = 1'($urandom);
      b8.B_in = 8'($urandom);
      b8.Q_in = 8'($urandom);
      @(negedge clk);
    end
    b4.start = 1'b0;
    b8.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
